// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU/EX writeback (requester 0) and the load/MEM writeback (requester 1).
// The granted write is registered and presented to the register file one
// cycle later; writes aimed at the hard-wired zero register are accepted
// but never issued. Issued and dropped writes are counted for debug.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_WIDTH-1:0] req_reg0,
  input  logic [DATA_WIDTH-1:0] req_data0,
  input  logic [ADDR_WIDTH-1:0] req_reg1,
  input  logic [DATA_WIDTH-1:0] req_data1,
  output logic [1:0]            req_ready,
  output logic                  REG_WRITE,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  // ptr_q names the requester that wins when both are valid
  logic                  ptr_q, ptr_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic                  xfer;
  logic                  sel;
  logic                  sel_zero;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;

  // Grant: one-hot or zero, only to a valid requester, held off during reset
  always_comb begin
    req_ready = 2'b00;
    if (rst_n && arb_en) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = ptr_q ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  // Next-state: pointer rotation, output register load and counter updates
  always_comb begin
    xfer         = |req_ready;
    sel          = req_ready[1];
    sel_reg      = sel ? req_reg1 : req_reg0;
    sel_data     = sel ? req_data1 : req_data0;
    sel_zero     = (sel_reg == ADDR_WIDTH'(ZERO_REG));
    ptr_d        = ptr_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    wr_count_d   = wr_count_q;
    drop_count_d = drop_count_q;
    if (xfer) begin
      // the requester that lost (or was idle) gets priority next time
      ptr_d = ~sel;
      if (sel_zero) begin
        drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end else begin
        reg_write_d  = 1'b1;
        write_reg_d  = sel_reg;
        write_data_d = sel_data;
        wr_count_d   = wr_count_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers; reset discards any pending write immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign REG_WRITE  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign writeData  = write_data_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
  assign busy       = reg_write_q | (|req_valid);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a simple register-file model.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        arb_en;
  logic [1:0]  req_valid;
  logic [4:0]  req_reg0, req_reg1;
  logic [63:0] req_data0, req_data1;
  logic [1:0]  req_ready;
  logic        REG_WRITE;
  logic [4:0]  write_reg;
  logic [63:0] writeData;
  logic        busy;
  logic [15:0] wr_count, drop_count;

  int checks = 0;
  int fails  = 0;

  logic [63:0] rf [32];

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
    .req_reg0(req_reg0), .req_data0(req_data0),
    .req_reg1(req_reg1), .req_data1(req_data1),
    .req_ready(req_ready), .REG_WRITE(REG_WRITE), .write_reg(write_reg),
    .writeData(writeData), .busy(busy), .wr_count(wr_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: stores every issued write, including index 31
  always @(posedge clk) begin
    if (REG_WRITE) rf[write_reg] <= writeData;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arb_en = 1'b1; req_valid = 2'b11;
    req_reg0 = 5'd1; req_data0 = 64'd1; req_reg1 = 5'd2; req_data1 = 64'd2;
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready actual=%b required=00", req_ready); end
    checks++; if (REG_WRITE !== 1'b0) begin fails++; $display("FAIL reset_reg_write actual=%b required=0", REG_WRITE); end
    checks++; if (write_reg !== 5'd0) begin fails++; $display("FAIL reset_write_reg actual=%0d required=0", write_reg); end
    checks++; if (writeData !== 64'd0) begin fails++; $display("FAIL reset_write_data actual=%0d required=0", writeData); end
    checks++; if (wr_count !== 16'd0) begin fails++; $display("FAIL reset_wr_count actual=%0d required=0", wr_count); end
    checks++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop_count actual=%0d required=0", drop_count); end
    tick();
    tick();
    checks++; if (REG_WRITE !== 1'b0) begin fails++; $display("FAIL reset_hold_reg_write actual=%b required=0", REG_WRITE); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    req_valid = 2'b01; req_reg0 = 5'd2; req_data0 = 64'd99999;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready actual=%b required=01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (REG_WRITE !== 1'b1) begin fails++; $display("FAIL single_reg_write actual=%b required=1", REG_WRITE); end
    checks++; if (write_reg !== 5'd2) begin fails++; $display("FAIL single_write_reg actual=%0d required=2", write_reg); end
    checks++; if (writeData !== 64'd99999) begin fails++; $display("FAIL single_write_data actual=%0d required=99999", writeData); end
    checks++; if (wr_count !== 16'd1) begin fails++; $display("FAIL single_wr_count actual=%0d required=1", wr_count); end
    tick();
    checks++; if (REG_WRITE !== 1'b0) begin fails++; $display("FAIL single_idle_reg_write actual=%b required=0", REG_WRITE); end
    checks++; if (write_reg !== 5'd2) begin fails++; $display("FAIL single_hold_write_reg actual=%0d required=2", write_reg); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy actual=%b required=0", busy); end
    $display("test_single X2=99999 wr_count=%0d", wr_count);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [4:0]  exp_reg   [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
    logic [63:0] exp_data  [4] = '{64'd11, 64'd22, 64'd11, 64'd22};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 2'b11;
    req_reg0 = 5'd3; req_data0 = 64'd11; req_reg1 = 5'd4; req_data1 = 64'd22;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== exp_ready[k]) begin fails++; $display("FAIL b2b_ready[%0d] actual=%b required=%b", k, req_ready, exp_ready[k]); end
      tick();
      checks++; if (REG_WRITE !== 1'b1) begin fails++; $display("FAIL b2b_reg_write[%0d] actual=%b required=1", k, REG_WRITE); end
      checks++; if (write_reg !== exp_reg[k]) begin fails++; $display("FAIL b2b_write_reg[%0d] actual=%0d required=%0d", k, write_reg, exp_reg[k]); end
      checks++; if (writeData !== exp_data[k]) begin fails++; $display("FAIL b2b_write_data[%0d] actual=%0d required=%0d", k, writeData, exp_data[k]); end
      $display("test_back_to_back beat %0d X%0d=%0d", k, write_reg, writeData);
    end
    req_valid = 2'b00;
    checks++; if (wr_count !== 16'd4) begin fails++; $display("FAIL b2b_wr_count actual=%0d required=4", wr_count); end
  endtask

  task automatic test_zero_reg();
    req_valid = 2'b10; req_reg1 = 5'd31; req_data1 = 64'd99999;
    #1;
    checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL xzr_ready actual=%b required=10", req_ready); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL xzr_busy actual=%b required=1", busy); end
    tick();
    req_valid = 2'b00;
    checks++; if (REG_WRITE !== 1'b0) begin fails++; $display("FAIL xzr_reg_write actual=%b required=0", REG_WRITE); end
    checks++; if (drop_count !== 16'd1) begin fails++; $display("FAIL xzr_drop_count actual=%0d required=1", drop_count); end
    checks++; if (wr_count !== 16'd4) begin fails++; $display("FAIL xzr_wr_count actual=%0d required=4", wr_count); end
    tick();
    checks++; if (rf[31] !== 64'd0) begin fails++; $display("FAIL xzr_read actual=%0d required=0", rf[31]); end
    $display("test_zero_reg X31 drop_count=%0d", drop_count);
  endtask

  task automatic test_arb_disable();
    // req0 alone first so the held pointer names requester 1
    arb_en = 1'b1; req_valid = 2'b01; req_reg0 = 5'd6; req_data0 = 64'd5;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL dis_pre_ready actual=%b required=01", req_ready); end
    tick();
    arb_en = 1'b0; req_valid = 2'b11;
    req_reg0 = 5'd10; req_data0 = 64'd100; req_reg1 = 5'd7; req_data1 = 64'd77;
    #1;
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL dis_ready actual=%b required=00", req_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (REG_WRITE !== 1'b0) begin fails++; $display("FAIL dis_reg_write[%0d] actual=%b required=0", k, REG_WRITE); end
      checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL dis_ready[%0d] actual=%b required=00", k, req_ready); end
      checks++; if (wr_count !== 16'd5) begin fails++; $display("FAIL dis_wr_count[%0d] actual=%0d required=5", k, wr_count); end
      checks++; if (drop_count !== 16'd1) begin fails++; $display("FAIL dis_drop_count[%0d] actual=%0d required=1", k, drop_count); end
    end
    arb_en = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL en_ready actual=%b required=10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (write_reg !== 5'd7) begin fails++; $display("FAIL en_write_reg actual=%0d required=7", write_reg); end
    checks++; if (writeData !== 64'd77) begin fails++; $display("FAIL en_write_data actual=%0d required=77", writeData); end
    checks++; if (wr_count !== 16'd6) begin fails++; $display("FAIL en_wr_count actual=%0d required=6", wr_count); end
    $display("test_arb_disable resumed with X%0d=%0d", write_reg, writeData);
  endtask

  task automatic test_same_dest();
    req_valid = 2'b11; req_reg0 = 5'd5; req_data0 = 64'd7; req_reg1 = 5'd5; req_data1 = 64'd9;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL same_ready0 actual=%b required=01", req_ready); end
    tick();
    req_valid = 2'b10;
    checks++; if (writeData !== 64'd7) begin fails++; $display("FAIL same_first_data actual=%0d required=7", writeData); end
    #1;
    checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL same_ready1 actual=%b required=10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (writeData !== 64'd9) begin fails++; $display("FAIL same_second_data actual=%0d required=9", writeData); end
    tick();
    checks++; if (rf[5] !== 64'd9) begin fails++; $display("FAIL same_read_x5 actual=%0d required=9", rf[5]); end
    checks++; if (wr_count !== 16'd8) begin fails++; $display("FAIL same_wr_count actual=%0d required=8", wr_count); end
    $display("test_same_dest X5=%0d", rf[5]);
  endtask

  task automatic test_mid_reset();
    req_valid = 2'b11; req_reg0 = 5'd8; req_data0 = 64'd1; req_reg1 = 5'd9; req_data1 = 64'd2;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_ready actual=%b required=01", req_ready); end
    tick();
    checks++; if (REG_WRITE !== 1'b1) begin fails++; $display("FAIL mid_pre_reg_write actual=%b required=1", REG_WRITE); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (REG_WRITE !== 1'b0) begin fails++; $display("FAIL mid_async_reg_write actual=%b required=0", REG_WRITE); end
    checks++; if (wr_count !== 16'd0) begin fails++; $display("FAIL mid_wr_count actual=%0d required=0", wr_count); end
    checks++; if (drop_count !== 16'd0) begin fails++; $display("FAIL mid_drop_count actual=%0d required=0", drop_count); end
    checks++; if (req_ready !== 2'b00) begin fails++; $display("FAIL mid_rst_ready actual=%b required=00", req_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin fails++; $display("FAIL mid_release_ready actual=%b required=01", req_ready); end
    tick();
    checks++; if (write_reg !== 5'd8) begin fails++; $display("FAIL mid_write_reg actual=%0d required=8", write_reg); end
    checks++; if (wr_count !== 16'd1) begin fails++; $display("FAIL mid_wr_count_after actual=%0d required=1", wr_count); end
    #1;
    checks++; if (req_ready !== 2'b10) begin fails++; $display("FAIL mid_next_ready actual=%b required=10", req_ready); end
    req_valid = 2'b00;
    $display("test_mid_reset first grant X%0d", write_reg);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    rst_n = 1'b0; arb_en = 1'b0; req_valid = 2'b00;
    req_reg0 = '0; req_reg1 = '0; req_data0 = '0; req_data1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_reg();
    test_arb_disable();
    test_same_dest();
    test_mid_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
